// File: rtl/multiply_accumulate_vec.sv
// Vector multiply-accumulate with a pipelined lane multiplier and adder tree.
//
// Each valid beat forms S = sum_i A_i*B_i over LANES signed lanes. A frame
// (inFirst .. inLast) accumulates C + S_0 + S_1 + ... into an OUT_WIDTH
// accumulator that either saturates or wraps. The final value is published
// on RES, together with a sticky overflow flag.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   enable          global clock enable; low freezes every register
//   inReady         beat valid
//   inFirst/inLast  frame delimiters, qualified by inReady
//   A, B            packed signed lanes, lane i = [i*IN_M_WIDTH +: IN_M_WIDTH]
//   C               signed addend, used only on the inFirst beat
//   outReady        RES/overflow hold a freshly completed frame result
//   RES, overflow   frame result and sticky frame overflow flag
//   earlyOutReady   outReady one enabled cycle ahead

// Single-lane signed multiplier, result sign-extended to the tree width.
module mac_lane_mul #(
  parameter int MW = 10,
  parameter int SW = 22
) (
  input  logic [MW-1:0] a_i,
  input  logic [MW-1:0] b_i,
  output logic [SW-1:0] p_o
);
  localparam int PW = 2 * MW;
  logic signed [PW-1:0] ae, be, p;
  assign ae  = PW'($signed(a_i));
  assign be  = PW'($signed(b_i));
  assign p   = ae * be;
  assign p_o = SW'(p);
endmodule

module multiply_accumulate_vec #(
  parameter int IN_M_WIDTH      = 10,
  parameter int IN_A_WIDTH      = 20,
  parameter int OUT_WIDTH       = 24,
  parameter int LANES           = 4,
  parameter int INPUT_REG_DEPTH = 1,
  parameter int MULT_PIPE_DEPTH = 1,
  parameter int SATURATE        = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          inReady,
  input  logic                          inFirst,
  input  logic                          inLast,
  input  logic [LANES*IN_M_WIDTH-1:0]   A,
  input  logic [LANES*IN_M_WIDTH-1:0]   B,
  input  logic [IN_A_WIDTH-1:0]         C,
  output logic                          outReady,
  output logic [OUT_WIDTH-1:0]          RES,
  output logic                          overflow,
  output logic                          earlyOutReady
);
  localparam int TD  = $clog2(LANES);
  localparam int IRD = INPUT_REG_DEPTH;
  localparam int MPD = MULT_PIPE_DEPTH;
  localparam int L   = IRD + MPD + TD + 1;
  // Tree width: full product plus one growth bit per adder level.
  localparam int SW  = 2 * IN_M_WIDTH + TD;
  // Accumulator add width: wide enough that the raw sum never wraps.
  localparam int WW  = ((OUT_WIDTH > SW) ? OUT_WIDTH : SW) + 1;
  localparam logic signed [WW-1:0] MAXV = {{(WW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [WW-1:0] MINV = ~MAXV;

  typedef logic [LANES-1:0][IN_M_WIDTH-1:0] lanes_t;

  // Control pipe: bit 0 is the live input, bit k is stage k.
  logic [L:0]   vld_pipe, lst_pipe;
  logic [L-1:0] vld_q, lst_q;
  logic [L-1:0] fst_pipe;

  assign vld_pipe = {vld_q, inReady};
  assign lst_pipe = {lst_q, inReady & inLast};

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      lst_q <= '0;
    end else if (enable) begin
      vld_q <= vld_pipe[L-1:0];
      lst_q <= lst_pipe[L-1:0];
    end
  end

  // The first flag is only needed up to the accumulator input.
  if (L == 1) begin : g_fst1
    assign fst_pipe = inReady & inFirst;
  end else begin : g_fstn
    logic [L-2:0] fst_q;
    assign fst_pipe = {fst_q, inReady & inFirst};
    always_ff @(posedge clk) begin
      if (reset)       fst_q <= '0;
      else if (enable) fst_q <= fst_pipe[L-2:0];
    end
  end

  // Input register stages.
  for (genvar k = 0; k <= IRD; k++) begin : g_in
    lanes_t a, b;
    if (k == 0) begin : g_src
      assign a = A;
      assign b = B;
    end else begin : g_reg
      always_ff @(posedge clk)
        if (enable && vld_pipe[k-1]) begin
          a <= g_in[k-1].a;
          b <= g_in[k-1].b;
        end
    end
  end

  // Addend rides alongside its first beat, all the way to the accumulator.
  for (genvar k = 0; k < L; k++) begin : g_c
    logic [IN_A_WIDTH-1:0] c;
    if (k == 0) begin : g_src
      assign c = C;
    end else begin : g_reg
      always_ff @(posedge clk)
        if (enable && vld_pipe[k-1] && fst_pipe[k-1]) c <= g_c[k-1].c;
    end
  end

  // Lane multipliers.
  logic [LANES-1:0][SW-1:0] prod;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane_mul #(.MW(IN_M_WIDTH), .SW(SW)) u_mul (
      .a_i (g_in[IRD].a[i]),
      .b_i (g_in[IRD].b[i]),
      .p_o (prod[i])
    );
  end

  // Multiplier pipeline stages.
  for (genvar m = 0; m <= MPD; m++) begin : g_mp
    logic [LANES-1:0][SW-1:0] p;
    if (m == 0) begin : g_src
      assign p = prod;
    end else begin : g_reg
      always_ff @(posedge clk)
        if (enable && vld_pipe[IRD+m-1]) p <= g_mp[m-1].p;
    end
  end

  // Registered pairwise adder tree; level l holds LANES>>l partial sums.
  for (genvar l = 0; l <= TD; l++) begin : g_tr
    localparam int N = LANES >> l;
    logic [N-1:0][SW-1:0] s;
    if (l == 0) begin : g_src
      assign s = g_mp[MPD].p;
    end else begin : g_add
      always_ff @(posedge clk)
        if (enable && vld_pipe[IRD+MPD+l-1])
          for (int j = 0; j < N; j++)
            s[j] <= g_tr[l-1].s[2*j] + g_tr[l-1].s[2*j+1];
    end
  end

  // Accumulator stage.
  logic [OUT_WIDTH-1:0]   acc_q, acc_d, res_q;
  logic                   ovf_q, ovf_d, ovf_res_q, ovf_ev;
  logic signed [WW-1:0]   base_w, sum_w;

  always_comb begin
    base_w = fst_pipe[L-1] ? WW'($signed(g_c[L-1].c)) : WW'($signed(acc_q));
    sum_w  = base_w + WW'($signed(g_tr[TD].s[0]));
    ovf_ev = (sum_w > MAXV) || (sum_w < MINV);
    acc_d  = sum_w[OUT_WIDTH-1:0];
    if (ovf_ev && (SATURATE != 0))
      acc_d = (sum_w > MAXV) ? MAXV[OUT_WIDTH-1:0] : MINV[OUT_WIDTH-1:0];
    // Sticky within a frame; a first beat starts a fresh flag.
    ovf_d  = ovf_ev | (~fst_pipe[L-1] & ovf_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      res_q     <= '0;
      ovf_res_q <= 1'b0;
    end else if (enable && vld_pipe[L-1]) begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
      if (lst_pipe[L-1]) begin
        res_q     <= acc_d;
        ovf_res_q <= ovf_d;
      end
    end
  end

  assign RES           = res_q;
  assign overflow      = ovf_res_q;
  assign outReady      = vld_pipe[L] & lst_pipe[L];
  assign earlyOutReady = vld_pipe[L-1] & lst_pipe[L-1];

endmodule
